// File: rtl/rename_pkg.sv
// Shared types and sizes for the 2-wide register rename stage.
package rename_pkg;

  localparam int ARCH_REGS  = 32;
  localparam int ARCH_WIDTH = 5;
  localparam int PHY_REGS   = 64;
  localparam int PHY_WIDTH  = 6;

  // Physical register 0 is a hard zero and is never handed out by the freelist
  localparam logic [PHY_WIDTH-1:0] PHY_ZERO = '0;

  typedef struct packed {
    logic [PHY_WIDTH-1:0] rs1_phy;
    logic [PHY_WIDTH-1:0] rs2_phy;
    logic [PHY_WIDTH-1:0] rd_phy;
    logic [PHY_WIDTH-1:0] rd_old_phy;
    logic                 rd_we;
  } ren_uop_t;

  // Architectural x0 always reads as the hard-zero physical register
  function automatic logic [PHY_WIDTH-1:0] src_phy(input logic [ARCH_WIDTH-1:0] arch,
                                                   input logic [PHY_WIDTH-1:0]  mapped);
    return (arch == '0) ? PHY_ZERO : mapped;
  endfunction

endpackage

// File: rtl/rename_map_table.sv
// Front register alias table: 6 combinational read ports, 2 ordered write
// ports (port 1 wins on a same-index collision) and a bulk restore from the
// committed map that takes priority over the write ports.
module rename_map_table
  import rename_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic [5:0][ARCH_WIDTH-1:0]          rd_addr,
  output logic [5:0][PHY_WIDTH-1:0]           rd_data,
  input  logic [1:0]                          wr_en,
  input  logic [1:0][ARCH_WIDTH-1:0]          wr_addr,
  input  logic [1:0][PHY_WIDTH-1:0]           wr_data,
  input  logic                                restore,
  input  logic [ARCH_REGS*PHY_WIDTH-1:0]      arch_map_flat
);

  logic [ARCH_REGS-1:0][PHY_WIDTH-1:0] rat_q;
  logic [ARCH_REGS-1:0][PHY_WIDTH-1:0] rat_d;

  // Read ports see the current table contents, no bypass of same-cycle writes
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < 6; k++) begin
      rd_data[k] = rat_q[rd_addr[k]];
    end
  end

  // Restore copies the flat committed map (entry i at bits i*PHY_WIDTH); else lane writes in order
  always_comb begin
    rat_d = rat_q;
    if (restore) begin
      rat_d = arch_map_flat;
    end else begin
      if (wr_en[0]) rat_d[wr_addr[0]] = wr_data[0];
      if (wr_en[1]) rat_d[wr_addr[1]] = wr_data[1];
    end
  end

  // Table register; reset maps every architectural register to the hard zero
  always_ff @(posedge clk) begin
    if (rst) rat_q <= '0;
    else     rat_q <= rat_d;
  end

endmodule

// File: rtl/rename_stage.sv
// 2-wide rename stage: RAT lookup with intra-group bypass, freelist
// allocation, and a valid/ready output register towards dispatch.
// Optional macro RENAME_PERF_CNT_EN adds three 32-bit stall/throughput counters.
module rename_stage
  import rename_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     dec_valid,
  input  logic [ARCH_WIDTH-1:0]          dec_rs1_0,
  input  logic [ARCH_WIDTH-1:0]          dec_rs2_0,
  input  logic [ARCH_WIDTH-1:0]          dec_rd_0,
  input  logic [ARCH_WIDTH-1:0]          dec_rs1_1,
  input  logic [ARCH_WIDTH-1:0]          dec_rs2_1,
  input  logic [ARCH_WIDTH-1:0]          dec_rd_1,
  input  logic [1:0]                     dec_rd_we,
  output logic                           dec_ready,
  input  logic [PHY_WIDTH-1:0]           fl_num_free,
  output logic [1:0]                     fl_alloc_valid,
  input  logic [PHY_WIDTH-1:0]           fl_rd_phy_new_0,
  input  logic [PHY_WIDTH-1:0]           fl_rd_phy_new_1,
  input  logic                           flush,
  input  logic [ARCH_REGS*PHY_WIDTH-1:0] arch_map_flat,
  output logic [1:0]                     ren_valid,
  input  logic                           ren_ready,
  output logic [PHY_WIDTH-1:0]           ren_rs1_phy_0,
  output logic [PHY_WIDTH-1:0]           ren_rs1_phy_1,
  output logic [PHY_WIDTH-1:0]           ren_rs2_phy_0,
  output logic [PHY_WIDTH-1:0]           ren_rs2_phy_1,
  output logic [PHY_WIDTH-1:0]           ren_rd_phy_0,
  output logic [PHY_WIDTH-1:0]           ren_rd_phy_1,
  output logic [PHY_WIDTH-1:0]           ren_rd_old_phy_0,
  output logic [PHY_WIDTH-1:0]           ren_rd_old_phy_1,
  output logic [1:0]                     ren_rd_we
`ifdef RENAME_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_stall_fl,
  output logic [31:0]                    perf_stall_disp,
  output logic [31:0]                    perf_renamed
`endif
);

  logic [1:0]                 need;
  logic [1:0]                 need_cnt;
  logic                       out_free;
  logic                       fl_enough;
  logic                       fire;
  logic [5:0][ARCH_WIDTH-1:0] rat_raddr;
  logic [5:0][PHY_WIDTH-1:0]  rat_rdata;
  logic [1:0]                 rat_wr_en;
  logic [1:0][ARCH_WIDTH-1:0] rat_wr_addr;
  logic [1:0][PHY_WIDTH-1:0]  rat_wr_data;
  ren_uop_t                   new_uop [2];
  ren_uop_t                   uop_d   [2];
  ren_uop_t                   uop_q   [2];
  logic [1:0]                 ren_valid_d;
  logic [1:0]                 ren_valid_q;

  assign rat_raddr = {dec_rd_1, dec_rs2_1, dec_rs1_1, dec_rd_0, dec_rs2_0, dec_rs1_0};

  rename_map_table u_map (
    .clk           (clk),
    .rst           (rst),
    .rd_addr       (rat_raddr),
    .rd_data       (rat_rdata),
    .wr_en         (rat_wr_en),
    .wr_addr       (rat_wr_addr),
    .wr_data       (rat_wr_data),
    .restore       (flush),
    .arch_map_flat (arch_map_flat)
  );

  // Handshake: accept a whole group only when the output slot frees and enough registers exist
  always_comb begin
    need[0]        = dec_valid[0] & dec_rd_we[0] & (dec_rd_0 != '0);
    need[1]        = dec_valid[1] & dec_rd_we[1] & (dec_rd_1 != '0);
    need_cnt       = {1'b0, need[0]} + {1'b0, need[1]};
    out_free       = (ren_valid_q == 2'b00) | ren_ready;
    fl_enough      = fl_num_free >= {{(PHY_WIDTH-2){1'b0}}, need_cnt};
    dec_ready      = out_free & ~flush & fl_enough;
    fire           = (|dec_valid) & dec_ready;
    fl_alloc_valid = fire ? need : 2'b00;
  end

  // Rename both lanes; lane 1 bypasses lane 0's new mapping when it reads or overwrites the same rd
  always_comb begin
    new_uop[0].rs1_phy    = src_phy(dec_rs1_0, rat_rdata[0]);
    new_uop[0].rs2_phy    = src_phy(dec_rs2_0, rat_rdata[1]);
    new_uop[0].rd_phy     = need[0] ? fl_rd_phy_new_0 : PHY_ZERO;
    new_uop[0].rd_old_phy = need[0] ? rat_rdata[2] : PHY_ZERO;
    new_uop[0].rd_we      = dec_valid[0] & dec_rd_we[0];

    new_uop[1].rs1_phy    = (need[0] && dec_rs1_1 == dec_rd_0) ? fl_rd_phy_new_0
                                                                : src_phy(dec_rs1_1, rat_rdata[3]);
    new_uop[1].rs2_phy    = (need[0] && dec_rs2_1 == dec_rd_0) ? fl_rd_phy_new_0
                                                                : src_phy(dec_rs2_1, rat_rdata[4]);
    new_uop[1].rd_phy     = need[1] ? fl_rd_phy_new_1 : PHY_ZERO;
    new_uop[1].rd_old_phy = !need[1] ? PHY_ZERO :
                            (need[0] && dec_rd_1 == dec_rd_0) ? fl_rd_phy_new_0 : rat_rdata[5];
    new_uop[1].rd_we      = dec_valid[1] & dec_rd_we[1];

    rat_wr_en      = fire ? need : 2'b00;
    rat_wr_addr[0] = dec_rd_0;
    rat_wr_addr[1] = dec_rd_1;
    rat_wr_data[0] = fl_rd_phy_new_0;
    rat_wr_data[1] = fl_rd_phy_new_1;
  end

  // Output slot: flush empties it, fire loads it, dispatch acceptance drains it, otherwise hold
  always_comb begin
    ren_valid_d = ren_valid_q;
    uop_d       = uop_q;
    if (flush) begin
      ren_valid_d = 2'b00;
    end else if (fire) begin
      ren_valid_d = dec_valid;
      uop_d       = new_uop;
    end else if (ren_ready) begin
      ren_valid_d = 2'b00;
    end
  end

  // Output pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      ren_valid_q <= 2'b00;
      uop_q[0]    <= '0;
      uop_q[1]    <= '0;
    end else begin
      ren_valid_q <= ren_valid_d;
      uop_q[0]    <= uop_d[0];
      uop_q[1]    <= uop_d[1];
    end
  end

  assign ren_valid        = ren_valid_q;
  assign ren_rs1_phy_0    = uop_q[0].rs1_phy;
  assign ren_rs2_phy_0    = uop_q[0].rs2_phy;
  assign ren_rd_phy_0     = uop_q[0].rd_phy;
  assign ren_rd_old_phy_0 = uop_q[0].rd_old_phy;
  assign ren_rs1_phy_1    = uop_q[1].rs1_phy;
  assign ren_rs2_phy_1    = uop_q[1].rs2_phy;
  assign ren_rd_phy_1     = uop_q[1].rd_phy;
  assign ren_rd_old_phy_1 = uop_q[1].rd_old_phy;
  assign ren_rd_we        = {uop_q[1].rd_we, uop_q[0].rd_we};

`ifdef RENAME_PERF_CNT_EN
  logic [31:0] perf_stall_fl_d,   perf_stall_fl_q;
  logic [31:0] perf_stall_disp_d, perf_stall_disp_q;
  logic [31:0] perf_renamed_d,    perf_renamed_q;

  // Wrapping event counters for freelist stalls, dispatch stalls and renamed uops
  always_comb begin
    perf_stall_fl_d   = perf_stall_fl_q   + {31'd0, (|dec_valid) & out_free & ~fl_enough};
    perf_stall_disp_d = perf_stall_disp_q + {31'd0, (|dec_valid) & ~out_free};
    perf_renamed_d    = perf_renamed_q;
    if (fire) perf_renamed_d = perf_renamed_q + {31'd0, dec_valid[0]} + {31'd0, dec_valid[1]};
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_fl_q   <= '0;
      perf_stall_disp_q <= '0;
      perf_renamed_q    <= '0;
    end else begin
      perf_stall_fl_q   <= perf_stall_fl_d;
      perf_stall_disp_q <= perf_stall_disp_d;
      perf_renamed_q    <= perf_renamed_d;
    end
  end

  assign perf_stall_fl   = perf_stall_fl_q;
  assign perf_stall_disp = perf_stall_disp_q;
  assign perf_renamed    = perf_renamed_q;
`endif

endmodule

// File: tb/tb_rename_stage.sv
// Testbench for rename_stage: directed scenarios followed by random traffic,
// all checked against a sequential-renaming reference model.
module tb_rename_stage;
  import rename_pkg::*;

  logic                           clk;
  logic                           rst;
  logic [1:0]                     dec_valid;
  logic [ARCH_WIDTH-1:0]          dec_rs1_0, dec_rs2_0, dec_rd_0;
  logic [ARCH_WIDTH-1:0]          dec_rs1_1, dec_rs2_1, dec_rd_1;
  logic [1:0]                     dec_rd_we;
  logic                           dec_ready;
  logic [PHY_WIDTH-1:0]           fl_num_free;
  logic [1:0]                     fl_alloc_valid;
  logic [PHY_WIDTH-1:0]           fl_rd_phy_new_0, fl_rd_phy_new_1;
  logic                           flush;
  logic [ARCH_REGS*PHY_WIDTH-1:0] arch_map_flat;
  logic [1:0]                     ren_valid;
  logic                           ren_ready;
  logic [PHY_WIDTH-1:0]           ren_rs1_phy_0, ren_rs1_phy_1, ren_rs2_phy_0, ren_rs2_phy_1;
  logic [PHY_WIDTH-1:0]           ren_rd_phy_0, ren_rd_phy_1, ren_rd_old_phy_0, ren_rd_old_phy_1;
  logic [1:0]                     ren_rd_we;
`ifdef RENAME_PERF_CNT_EN
  logic [31:0]                    perf_stall_fl, perf_stall_disp, perf_renamed;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rename_stage dut (
    .clk              (clk),
    .rst              (rst),
    .dec_valid        (dec_valid),
    .dec_rs1_0        (dec_rs1_0),
    .dec_rs2_0        (dec_rs2_0),
    .dec_rd_0         (dec_rd_0),
    .dec_rs1_1        (dec_rs1_1),
    .dec_rs2_1        (dec_rs2_1),
    .dec_rd_1         (dec_rd_1),
    .dec_rd_we        (dec_rd_we),
    .dec_ready        (dec_ready),
    .fl_num_free      (fl_num_free),
    .fl_alloc_valid   (fl_alloc_valid),
    .fl_rd_phy_new_0  (fl_rd_phy_new_0),
    .fl_rd_phy_new_1  (fl_rd_phy_new_1),
    .flush            (flush),
    .arch_map_flat    (arch_map_flat),
    .ren_valid        (ren_valid),
    .ren_ready        (ren_ready),
    .ren_rs1_phy_0    (ren_rs1_phy_0),
    .ren_rs1_phy_1    (ren_rs1_phy_1),
    .ren_rs2_phy_0    (ren_rs2_phy_0),
    .ren_rs2_phy_1    (ren_rs2_phy_1),
    .ren_rd_phy_0     (ren_rd_phy_0),
    .ren_rd_phy_1     (ren_rd_phy_1),
    .ren_rd_old_phy_0 (ren_rd_old_phy_0),
    .ren_rd_old_phy_1 (ren_rd_old_phy_1),
    .ren_rd_we        (ren_rd_we)
`ifdef RENAME_PERF_CNT_EN
    ,
    .perf_stall_fl    (perf_stall_fl),
    .perf_stall_disp  (perf_stall_disp),
    .perf_renamed     (perf_renamed)
`endif
  );

  int         checks;
  int         failures;

  // Reference model: architectural->physical map, committed map and the output slot contents
  int         m_rat  [ARCH_REGS];
  int         m_arch [ARCH_REGS];
  logic [1:0] m_valid;
  int         m_rs1 [2];
  int         m_rs2 [2];
  int         m_rd  [2];
  int         m_old [2];
  int         m_we  [2];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid,
                               input int rs1a, input int rs2a, input int rda,
                               input int rs1b, input int rs2b, input int rdb,
                               input logic [1:0] we, input int num_free,
                               input int new_a, input int new_b,
                               input logic ready, input logic do_flush, input logic do_reset);
    dec_valid       = valid;
    dec_rs1_0       = ARCH_WIDTH'(rs1a);
    dec_rs2_0       = ARCH_WIDTH'(rs2a);
    dec_rd_0        = ARCH_WIDTH'(rda);
    dec_rs1_1       = ARCH_WIDTH'(rs1b);
    dec_rs2_1       = ARCH_WIDTH'(rs2b);
    dec_rd_1        = ARCH_WIDTH'(rdb);
    dec_rd_we       = we;
    fl_num_free     = PHY_WIDTH'(num_free);
    fl_rd_phy_new_0 = PHY_WIDTH'(new_a);
    fl_rd_phy_new_1 = PHY_WIDTH'(new_b);
    ren_ready       = ready;
    flush           = do_flush;
    rst             = do_reset;
  endtask

  // Random committed map with nonzero entries, optionally pinning one entry
  task automatic setArchMap(input int fix_idx, input int fix_val);
    for (int i = 0; i < ARCH_REGS; i++) begin
      m_arch[i] = (i == 0) ? 0 : int'($urandom_range(1, 63));
      if (i == fix_idx && i != 0) m_arch[i] = fix_val;
      arch_map_flat[i*PHY_WIDTH +: PHY_WIDTH] = PHY_WIDTH'(m_arch[i]);
    end
  endtask

  // One clock: check handshake before the edge, advance the model, check the output register after it
  task automatic stepCycle();
    int   rs1 [2];
    int   rs2 [2];
    int   rd  [2];
    int   np  [2];
    bit   need [2];
    int   tmp [ARCH_REGS];
    int   e_rs1 [2];
    int   e_rs2 [2];
    int   e_rd  [2];
    int   e_old [2];
    int   e_we  [2];
    int   regs_needed;
    bit   out_free, exp_ready, exp_fire;
    logic [1:0] exp_alloc;

    #1;
    rs1[0] = int'(dec_rs1_0); rs2[0] = int'(dec_rs2_0); rd[0] = int'(dec_rd_0);
    rs1[1] = int'(dec_rs1_1); rs2[1] = int'(dec_rs2_1); rd[1] = int'(dec_rd_1);
    np[0]  = int'(fl_rd_phy_new_0);
    np[1]  = int'(fl_rd_phy_new_1);
    regs_needed = 0;
    for (int l = 0; l < 2; l++) begin
      need[l] = dec_valid[l] && dec_rd_we[l] && rd[l] != 0;
      if (need[l]) regs_needed++;
    end
    out_free  = (m_valid == 2'b00) || ren_ready;
    exp_ready = out_free && !flush && (int'(fl_num_free) >= regs_needed);
    exp_fire  = (dec_valid != 2'b00) && exp_ready;
    exp_alloc = exp_fire ? {need[1], need[0]} : 2'b00;
    checkOutput("dec_ready", 32'(dec_ready), 32'(exp_ready));
    checkOutput("fl_alloc_valid", 32'(fl_alloc_valid), 32'(exp_alloc));

    // Rename lane 0 then lane 1 against a working copy of the map, exactly as sequential code would
    for (int i = 0; i < ARCH_REGS; i++) tmp[i] = m_rat[i];
    for (int l = 0; l < 2; l++) begin
      e_rs1[l] = (rs1[l] == 0) ? 0 : tmp[rs1[l]];
      e_rs2[l] = (rs2[l] == 0) ? 0 : tmp[rs2[l]];
      e_rd[l]  = need[l] ? np[l] : 0;
      e_old[l] = need[l] ? tmp[rd[l]] : 0;
      e_we[l]  = (dec_valid[l] && dec_rd_we[l]) ? 1 : 0;
      if (need[l]) tmp[rd[l]] = np[l];
    end

    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) m_rat[i] = 0;
      m_valid = 2'b00;
    end else if (flush) begin
      for (int i = 0; i < ARCH_REGS; i++) m_rat[i] = m_arch[i];
      m_valid = 2'b00;
    end else if (exp_fire) begin
      for (int i = 0; i < ARCH_REGS; i++) m_rat[i] = tmp[i];
      m_valid = dec_valid;
      for (int l = 0; l < 2; l++) begin
        m_rs1[l] = e_rs1[l]; m_rs2[l] = e_rs2[l]; m_rd[l] = e_rd[l];
        m_old[l] = e_old[l]; m_we[l]  = e_we[l];
      end
    end else if (ren_ready) begin
      m_valid = 2'b00;
    end

    #1;
    checkOutput("ren_valid", 32'(ren_valid), 32'(m_valid));
    if (m_valid[0]) begin
      checkOutput("rs1_phy_0", 32'(ren_rs1_phy_0), 32'(m_rs1[0]));
      checkOutput("rs2_phy_0", 32'(ren_rs2_phy_0), 32'(m_rs2[0]));
      checkOutput("rd_phy_0", 32'(ren_rd_phy_0), 32'(m_rd[0]));
      checkOutput("rd_old_phy_0", 32'(ren_rd_old_phy_0), 32'(m_old[0]));
      checkOutput("rd_we_0", 32'(ren_rd_we[0]), 32'(m_we[0]));
    end
    if (m_valid[1]) begin
      checkOutput("rs1_phy_1", 32'(ren_rs1_phy_1), 32'(m_rs1[1]));
      checkOutput("rs2_phy_1", 32'(ren_rs2_phy_1), 32'(m_rs2[1]));
      checkOutput("rd_phy_1", 32'(ren_rd_phy_1), 32'(m_rd[1]));
      checkOutput("rd_old_phy_1", 32'(ren_rd_old_phy_1), 32'(m_old[1]));
      checkOutput("rd_we_1", 32'(ren_rd_we[1]), 32'(m_we[1]));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_valid  = 2'b00;
    for (int i = 0; i < ARCH_REGS; i++) m_rat[i] = 0;
    for (int l = 0; l < 2; l++) begin
      m_rs1[l] = 0; m_rs2[l] = 0; m_rd[l] = 0; m_old[l] = 0; m_we[l] = 0;
    end
    setArchMap(0, 0);

    // Reset: two unchecked edges to clear X, then a checked reset cycle
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 63, 1, 2, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    stepCycle();
    checkOutput("reset ren_valid", 32'(ren_valid), 32'd0);
    checkOutput("reset rd_phy_0", 32'(ren_rd_phy_0), 32'd0);
    checkOutput("reset rd_old_phy_1", 32'(ren_rd_old_phy_1), 32'd0);
    checkOutput("reset rs1_phy_1", 32'(ren_rs1_phy_1), 32'd0);
    checkOutput("reset rd_we", 32'(ren_rd_we), 32'd0);

    // add x1,x0,x0 on lane 0 with new physical 1
    applyStimulus(2'b01, 0, 0, 1, 0, 0, 0, 2'b01, 63, 1, 2, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("t1 ren_valid", 32'(ren_valid), 32'd1);
    checkOutput("t1 rd_phy_0", 32'(ren_rd_phy_0), 32'd1);
    checkOutput("t1 rd_old_phy_0", 32'(ren_rd_old_phy_0), 32'd0);
    checkOutput("t1 rs1_phy_0", 32'(ren_rs1_phy_0), 32'd0);

    // Same-group dependency: both lanes write x1, lane 1 reads x1
    applyStimulus(2'b11, 0, 0, 1, 1, 0, 1, 2'b11, 63, 2, 3, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("t2 fl_alloc_valid", 32'(fl_alloc_valid), 32'd3);
    stepCycle();
    checkOutput("t2 rd_old_phy_0", 32'(ren_rd_old_phy_0), 32'd1);
    checkOutput("t2 rs1_phy_1", 32'(ren_rs1_phy_1), 32'd2);
    checkOutput("t2 rd_old_phy_1", 32'(ren_rd_old_phy_1), 32'd2);
    checkOutput("t2 rd_phy_1", 32'(ren_rd_phy_1), 32'd3);

    // One free register for a two-register group: stall, then raise to 2 within the cycle
    applyStimulus(2'b11, 0, 0, 1, 0, 0, 2, 2'b11, 1, 4, 5, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("t3 dec_ready low", 32'(dec_ready), 32'd0);
    checkOutput("t3 no alloc", 32'(fl_alloc_valid), 32'd0);
    fl_num_free = 6'd2;
    stepCycle();
    checkOutput("t3 rd_old_phy_0", 32'(ren_rd_old_phy_0), 32'd3);

    // x0 destination on lane 0 does not allocate; lane 1 takes new_1
    applyStimulus(2'b11, 1, 2, 0, 0, 0, 5, 2'b11, 63, 8, 9, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("t4 fl_alloc_valid", 32'(fl_alloc_valid), 32'd2);
    stepCycle();
    checkOutput("t4 rd_phy_0", 32'(ren_rd_phy_0), 32'd0);
    checkOutput("t4 rd_phy_1", 32'(ren_rd_phy_1), 32'd9);

    // Dispatch back-pressure for 3 cycles with a group pending, then release
    applyStimulus(2'b01, 1, 0, 6, 0, 0, 0, 2'b01, 63, 10, 11, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput("t5 held rd_phy_1", 32'(ren_rd_phy_1), 32'd9);
      checkOutput("t5 held valid", 32'(ren_valid), 32'd3);
    end
    ren_ready = 1'b1;
    stepCycle();
    checkOutput("t5 released valid", 32'(ren_valid), 32'd1);
    checkOutput("t5 released rd_phy_0", 32'(ren_rd_phy_0), 32'd10);

    // Rename x3 -> 7, then flush with committed x3 -> 4 while the group is still held
    applyStimulus(2'b01, 0, 0, 3, 0, 0, 0, 2'b01, 63, 7, 12, 1'b1, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(2'b01, 0, 0, 4, 0, 0, 0, 2'b01, 63, 11, 12, 1'b0, 1'b1, 1'b0);
    setArchMap(3, 4);
    #1;
    checkOutput("t6 flush no alloc", 32'(fl_alloc_valid), 32'd0);
    stepCycle();
    checkOutput("t6 flush valid", 32'(ren_valid), 32'd0);
    applyStimulus(2'b01, 3, 0, 0, 0, 0, 0, 2'b00, 63, 13, 14, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("t6 x3 restored", 32'(ren_rs1_phy_0), 32'd4);

    // Random traffic with dependencies, shortages, back-pressure, flushes and resets
    for (int n = 0; n < 600; n++) begin
      int sel_free;
      int num_free;
      logic do_flush;
      sel_free = int'($urandom_range(0, 9));
      num_free = (sel_free < 3) ? int'($urandom_range(0, 2)) : 63;
      do_flush = ($urandom_range(0, 19) == 0);
      if (do_flush) setArchMap(0, 0);
      applyStimulus(2'($urandom_range(0, 3)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)), num_free,
                    int'($urandom_range(1, 63)), int'($urandom_range(1, 63)),
                    ($urandom_range(0, 3) != 0), do_flush, ($urandom_range(0, 49) == 0));
      stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
